// File: rtl/radix_mult_if.sv
// Handshake and operand bundle for the radix_mult shift-and-add multiplier.
// The master side supplies operands and control; the slave side is the multiplier.
interface radix_mult_if #(
    parameter int WIDTH        = 1024,
    parameter int RESULT_WIDTH = 2 * WIDTH
);
    logic [WIDTH-1:0]        a_in;
    logic [WIDTH-1:0]        b_in;
    logic                    square_in;
    logic                    start_in;
    logic                    abort_in;
    logic                    ack_in;
    logic                    ready_out;
    logic                    busy_out;
    logic                    valid_out;
    logic [RESULT_WIDTH-1:0] result_out;

    modport master (
        output a_in, b_in, square_in, start_in, abort_in, ack_in,
        input  ready_out, busy_out, valid_out, result_out
    );

    modport slave (
        input  a_in, b_in, square_in, start_in, abort_in, ack_in,
        output ready_out, busy_out, valid_out, result_out
    );
endinterface

// File: rtl/radix_mult.sv
// Sequential radix-2^DIGIT_BITS shift-and-add multiplier.
// Each MULT cycle folds one multiplier digit into the accumulator; the
// multiplier register shifts right so the run ends as soon as no nonzero
// digits remain. Legal parameters: 1 <= DIGIT_BITS <= WIDTH and
// WIDTH % DIGIT_BITS == 0; RESULT_WIDTH is derived and must not be overridden.
module radix_mult #(
    parameter int WIDTH        = 1024,
    parameter int DIGIT_BITS   = 4,
    parameter int RESULT_WIDTH = 2 * WIDTH
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    radix_mult_if.slave    bus
);
    localparam int NUM_DIGITS = WIDTH / DIGIT_BITS;
    localparam int CNT_W      = $clog2(NUM_DIGITS) + 1;
    localparam int SHAMT_W    = $clog2(RESULT_WIDTH) + 1;
    localparam int PP_W       = WIDTH + DIGIT_BITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state_r;
    logic [WIDTH-1:0]        a_reg_r;
    logic [WIDTH-1:0]        rem_r;
    logic [RESULT_WIDTH-1:0] acc_r;
    logic [CNT_W-1:0]        dig_cnt_r;
    logic [RESULT_WIDTH-1:0] result_r;
    logic                    valid_r;

    logic [DIGIT_BITS-1:0]   digit_s;
    logic [PP_W-1:0]         pp_s;
    logic [SHAMT_W-1:0]      shamt_s;
    logic [RESULT_WIDTH-1:0] addend_s;
    logic [RESULT_WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0]        rem_next_s;

    // Partial product of the current low digit, aligned to its digit position.
    // Operands are zero-extended to the partial-product width so the product
    // cannot overflow; the aligned sum always fits in RESULT_WIDTH.
    assign digit_s    = rem_r[DIGIT_BITS-1:0];
    assign pp_s       = {{DIGIT_BITS{1'b0}}, a_reg_r} * {{WIDTH{1'b0}}, digit_s};
    assign shamt_s    = SHAMT_W'(dig_cnt_r) * SHAMT_W'(DIGIT_BITS);
    assign addend_s   = RESULT_WIDTH'(pp_s) << shamt_s;
    assign acc_next_s = acc_r + addend_s;
    assign rem_next_s = rem_r >> DIGIT_BITS;

    // Control FSM and datapath registers; abort outranks completion in MULT.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r   <= IDLE;
            a_reg_r   <= '0;
            rem_r     <= '0;
            acc_r     <= '0;
            dig_cnt_r <= '0;
            result_r  <= '0;
            valid_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start_in) begin
                        a_reg_r   <= bus.a_in;
                        rem_r     <= bus.square_in ? bus.a_in : bus.b_in;
                        acc_r     <= '0;
                        dig_cnt_r <= '0;
                        state_r   <= MULT;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                MULT: begin
                    if (bus.abort_in) begin
                        acc_r   <= '0;
                        state_r <= IDLE;
                    end else if (rem_r == '0) begin
                        result_r <= acc_r;
                        valid_r  <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        acc_r     <= acc_next_s;
                        rem_r     <= rem_next_s;
                        dig_cnt_r <= dig_cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.ack_in) begin
                        valid_r <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Status decoded purely from registered state; no input-to-output path.
    assign bus.ready_out  = (state_r == IDLE);
    assign bus.busy_out   = (state_r == MULT);
    assign bus.valid_out  = valid_r;
    assign bus.result_out = result_r;
endmodule

// File: tb/tb_radix_mult.sv
// Directed-vector bench for radix_mult at WIDTH=8, DIGIT_BITS=2.
module tb_radix_mult;
    localparam int W  = 8;
    localparam int D  = 2;
    localparam int RW = 2 * W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    radix_mult_if #(.WIDTH(W)) bus ();

    radix_mult #(.WIDTH(W), .DIGIT_BITS(D)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    // Present operands at a negedge; returns at the negedge after acceptance edge E0.
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic sq);
        bus.a_in      = a;
        bus.b_in      = b;
        bus.square_in = sq;
        bus.start_in  = 1'b1;
        @(negedge clk);
        bus.start_in  = 1'b0;
    endtask

    // Returns k where valid_out was first seen after edge E(k); 0 if the bound expired.
    task automatic wait_valid(input int bound, output int k);
        k = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic do_ack();
        bus.ack_in = 1'b1;
        @(negedge clk);
        bus.ack_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.ready_out); end
        n_cmp++; if (bus.busy_out !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_out); end
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
        n_cmp++; if (bus.result_out !== 16'h0000) begin n_bad++; $display("FAIL reset_result: got %h want 0000", bus.result_out); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", bus.ready_out); end
    endtask

    task automatic test_full_ff();
        bus.ack_in = 1'b1;
        do_start(8'hFF, 8'hFF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (bus.busy_out !== 1'b1) begin n_bad++; $display("FAIL ff_busy_E%0d: got %b want 1", k, bus.busy_out); end
            n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL ff_early_valid_E%0d: got %b want 0", k, bus.valid_out); end
            @(negedge clk);
        end
        n_cmp++; if (bus.valid_out !== 1'b1) begin n_bad++; $display("FAIL ff_valid_E5: got %b want 1", bus.valid_out); end
        n_cmp++; if (bus.result_out !== 16'hFE01) begin n_bad++; $display("FAIL ff_result: got %h want fe01", bus.result_out); end
        n_cmp++; if (bus.busy_out !== 1'b0) begin n_bad++; $display("FAIL ff_busy_E5: got %b want 0", bus.busy_out); end
        @(negedge clk);
        bus.ack_in = 1'b0;
        n_cmp++; if (bus.ready_out !== 1'b1) begin n_bad++; $display("FAIL ff_ready_E6: got %b want 1", bus.ready_out); end
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL ff_valid_E6: got %b want 0", bus.valid_out); end
    endtask

    task automatic test_square();
        int lat;
        do_start(8'd13, 8'hAA, 1'b1);
        wait_valid(12, lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL square_latency: got %0d want 3", lat); end
        n_cmp++; if (bus.result_out !== 16'h00A9) begin n_bad++; $display("FAIL square_result: got %h want 00a9", bus.result_out); end
        do_ack();
        n_cmp++; if (bus.ready_out !== 1'b1) begin n_bad++; $display("FAIL square_ready: got %b want 1", bus.ready_out); end
    endtask

    task automatic test_zero();
        logic [W-1:0] ta [3] = '{8'h00, 8'h05, 8'h00};
        logic [W-1:0] tb [3] = '{8'h55, 8'h00, 8'hFF};
        logic         ts [3] = '{1'b1, 1'b0, 1'b0};
        int           tl [3] = '{1, 1, 5};
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_start(ta[i], tb[i], ts[i]);
            wait_valid(12, lat);
            n_cmp++; if (lat !== tl[i]) begin n_bad++; $display("FAIL zero_latency[%0d]: got %0d want %0d", i, lat, tl[i]); end
            n_cmp++; if (bus.result_out !== 16'h0000) begin n_bad++; $display("FAIL zero_result[%0d]: got %h want 0000", i, bus.result_out); end
            do_ack();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        do_start(8'd7, 8'd9, 1'b0);
        wait_valid(12, lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL bp_latency: got %0d want 3", lat); end
        n_cmp++; if (bus.result_out !== 16'h003F) begin n_bad++; $display("FAIL bp_result: got %h want 003f", bus.result_out); end
        for (int i = 0; i < 10; i++) begin
            bus.a_in     = W'(i + 1);
            bus.b_in     = W'(i + 2);
            bus.start_in = 1'b1;
            @(negedge clk);
            n_cmp++; if (bus.result_out !== 16'h003F) begin n_bad++; $display("FAIL bp_hold_result[%0d]: got %h want 003f", i, bus.result_out); end
            n_cmp++; if (bus.valid_out !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus.valid_out); end
            n_cmp++; if (bus.ready_out !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, bus.ready_out); end
            n_cmp++; if (bus.busy_out !== 1'b0) begin n_bad++; $display("FAIL bp_hold_busy[%0d]: got %b want 0", i, bus.busy_out); end
        end
        bus.a_in     = 8'd3;
        bus.b_in     = 8'd3;
        bus.square_in = 1'b0;
        bus.ack_in   = 1'b1;
        @(negedge clk);
        bus.ack_in   = 1'b0;
        n_cmp++; if (bus.ready_out !== 1'b1) begin n_bad++; $display("FAIL bp_start_with_ack_ignored: ready got %b want 1", bus.ready_out); end
        n_cmp++; if (bus.result_out !== 16'h003F) begin n_bad++; $display("FAIL bp_result_after_ack: got %h want 003f", bus.result_out); end
        @(negedge clk);
        bus.start_in = 1'b0;
        n_cmp++; if (bus.busy_out !== 1'b1) begin n_bad++; $display("FAIL bp_next_accept: busy got %b want 1", bus.busy_out); end
        wait_valid(12, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL bp_next_latency: got %0d want 2", lat); end
        n_cmp++; if (bus.result_out !== 16'h0009) begin n_bad++; $display("FAIL bp_next_result: got %h want 0009", bus.result_out); end
        do_ack();
    endtask

    task automatic test_abort();
        int lat;
        int rose;
        do_start(8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        bus.abort_in = 1'b1;
        @(negedge clk);
        bus.abort_in = 1'b0;
        n_cmp++; if (bus.ready_out !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", bus.ready_out); end
        n_cmp++; if (bus.busy_out !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy_out); end
        n_cmp++; if (bus.result_out !== 16'h0009) begin n_bad++; $display("FAIL abort_result_kept: got %h want 0009", bus.result_out); end
        rose = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.valid_out !== 1'b0) rose = 1;
        end
        n_cmp++; if (rose !== 0) begin n_bad++; $display("FAIL abort_no_valid: got %0d want 0", rose); end
        // abort coinciding with rem==0 must win over completion
        do_start(8'd5, 8'd1, 1'b0);
        @(negedge clk);
        bus.abort_in = 1'b1;
        @(negedge clk);
        bus.abort_in = 1'b0;
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL abort_vs_done_valid: got %b want 0", bus.valid_out); end
        n_cmp++; if (bus.ready_out !== 1'b1) begin n_bad++; $display("FAIL abort_vs_done_ready: got %b want 1", bus.ready_out); end
        n_cmp++; if (bus.result_out !== 16'h0009) begin n_bad++; $display("FAIL abort_vs_done_result: got %h want 0009", bus.result_out); end
        // abort has no effect once the result is held
        do_start(8'd2, 8'd3, 1'b0);
        wait_valid(12, lat);
        bus.abort_in = 1'b1;
        @(negedge clk);
        bus.abort_in = 1'b0;
        n_cmp++; if (bus.valid_out !== 1'b1) begin n_bad++; $display("FAIL abort_in_done_valid: got %b want 1", bus.valid_out); end
        n_cmp++; if (bus.result_out !== 16'h0006) begin n_bad++; $display("FAIL abort_in_done_result: got %h want 0006", bus.result_out); end
        do_ack();
    endtask

    task automatic test_async_reset();
        int lat;
        do_start(8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.ready_out !== 1'b1) begin n_bad++; $display("FAIL areset_ready: got %b want 1", bus.ready_out); end
        n_cmp++; if (bus.busy_out !== 1'b0) begin n_bad++; $display("FAIL areset_busy: got %b want 0", bus.busy_out); end
        n_cmp++; if (bus.result_out !== 16'h0000) begin n_bad++; $display("FAIL areset_result: got %h want 0000", bus.result_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.ready_out !== 1'b1) begin n_bad++; $display("FAIL areset_release_ready: got %b want 1", bus.ready_out); end
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL areset_release_valid: got %b want 0", bus.valid_out); end
        // reset while a result is held
        do_start(8'h0E, 8'h00, 1'b1);
        wait_valid(12, lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL areset_sq_latency: got %0d want 3", lat); end
        n_cmp++; if (bus.result_out !== 16'h00C4) begin n_bad++; $display("FAIL areset_sq_result: got %h want 00c4", bus.result_out); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL areset_done_valid: got %b want 0", bus.valid_out); end
        n_cmp++; if (bus.result_out !== 16'h0000) begin n_bad++; $display("FAIL areset_done_result: got %h want 0000", bus.result_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  va [7] = '{8'h80, 8'h01, 8'hFF, 8'hFF, 8'h12, 8'hAB, 8'h03};
        logic [W-1:0]  vb [7] = '{8'h02, 8'h80, 8'h40, 8'h00, 8'h34, 8'hCD, 8'h01};
        logic          vs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [RW-1:0] vp [7] = '{16'h0100, 16'h0080, 16'h3FC0, 16'hFE01, 16'h03A8, 16'h88EF, 16'h0003};
        int            vl [7] = '{2, 5, 5, 5, 4, 5, 2};
        int lat;
        for (int i = 0; i < 7; i++) begin
            do_start(va[i], vb[i], vs[i]);
            wait_valid(12, lat);
            n_cmp++; if (lat !== vl[i]) begin n_bad++; $display("FAIL vec_latency[%0d]: got %0d want %0d", i, lat, vl[i]); end
            n_cmp++; if (bus.result_out !== vp[i]) begin n_bad++; $display("FAIL vec_result[%0d]: got %h want %h", i, bus.result_out, vp[i]); end
            for (int d = 0; d < (i % 3); d++) begin
                @(negedge clk);
                n_cmp++; if (bus.valid_out !== 1'b1 || bus.result_out !== vp[i]) begin
                    n_bad++; $display("FAIL vec_hold[%0d]: got valid %b result %h want 1 %h", i, bus.valid_out, bus.result_out, vp[i]);
                end
            end
            do_ack();
            n_cmp++; if (bus.ready_out !== 1'b1) begin n_bad++; $display("FAIL vec_ready[%0d]: got %b want 1", i, bus.ready_out); end
        end
    endtask

    initial begin
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.square_in = 1'b0;
        bus.start_in  = 1'b0;
        bus.abort_in  = 1'b0;
        bus.ack_in    = 1'b0;
        test_reset();
        test_full_ff();
        test_square();
        test_zero();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/radix_mult.md
Name: radix_mult

Overview:
- Parametrised sequential shift-and-add multiplier for the big-integer datapath. Computes a 2*WIDTH-bit product.
- Consumes DIGIT_BITS multiplier bits per cycle and stops early once the remaining multiplier bits are zero.
- Optional squaring mode uses operand A as both operands.
- Operands are latched on acceptance. The result is held under a valid/ack handshake.
- Supports abort.

Parameters:
- WIDTH, 1024: operand width in bits.
- DIGIT_BITS, 4: multiplier bits consumed per cycle. Must satisfy 1 <= DIGIT_BITS <= WIDTH and WIDTH % DIGIT_BITS == 0.
- RESULT_WIDTH, 2*WIDTH: product width. Derived; do not override.

Ports:
- clk_in, input, 1: clock. All state changes on the rising edge.
- rst_n_in, input, 1: asynchronous active-low reset.
- a_in, input, WIDTH: multiplicand.
- b_in, input, WIDTH: multiplier. Ignored when square_in=1.
- square_in, input, 1: 1 = compute a_in*a_in.
- start_in, input, 1: request. Accepted only while ready_out=1.
- abort_in, input, 1: cancel an in-flight multiply.
- ack_in, input, 1: consumer has taken result_out.
- ready_out, output, 1: high iff state IDLE.
- busy_out, output, 1: high iff state MULT.
- valid_out, output, 1: result_out holds a completed product.
- result_out, output, RESULT_WIDTH: product.

Behaviour:
- Reset: asynchronous, active-low. While rst_n_in=0:
  - state=IDLE, accumulator=0, result_out=0, valid_out=0, busy_out=0, ready_out=1.
  - Reset mid-MULT or mid-DONE discards everything; no valid_out pulse follows.
- Internal registers: a_reg (WIDTH), rem (WIDTH), acc (RESULT_WIDTH), dig_cnt (clog2(WIDTH/DIGIT_BITS)+1 bits).
- IDLE:
  - On edge with start_in=1: a_reg<=a_in; rem<=(square_in ? a_in : b_in); acc<=0; dig_cnt<=0; go to MULT.
  - Edge where start is accepted = E0. Inputs are not sampled again until the next acceptance.
- MULT, each edge, in priority order:
  - abort_in=1: go to IDLE. acc discarded, valid_out stays 0, result_out unchanged.
  - else rem==0: result_out<=acc; valid_out<=1; go to DONE.
  - else: acc <= acc + ((a_reg * rem[DIGIT_BITS-1:0]) << (dig_cnt*DIGIT_BITS)); rem <= rem >> DIGIT_BITS; dig_cnt++.
- Arithmetic and widths:
  - Partial product is WIDTH+DIGIT_BITS bits, zero-extended to RESULT_WIDTH.
  - The sum never exceeds RESULT_WIDTH; no truncation is possible.
  - A zero digit still consumes one cycle.
- Latency:
  - N = index of the highest nonzero DIGIT_BITS-digit of the effective multiplier, plus 1. N=0 when the multiplier is zero.
  - valid_out rises after edge E(N+1).
  - Maximum latency is WIDTH/DIGIT_BITS+1 edges.
- DONE:
  - result_out and valid_out held stable until ack_in=1.
  - On an ack edge: valid_out<=0; go to IDLE. result_out keeps its last value.
  - start_in is ignored in DONE, including when it coincides with ack; the new start is accepted on a later IDLE edge.
  - abort_in is ignored in DONE.
- start_in is ignored in MULT.
- ack_in is ignored outside DONE.
- Simultaneous abort_in and rem==0 in MULT: abort wins.
- ready_out and busy_out are decoded from the state register. No combinational path from any input to any output.

Test Plan:
- WIDTH=8, DIGIT_BITS=2; a=0xFF, b=0xFF, square_in=0, start at E0, ack held 1 -> busy_out E0..E4, valid_out=1 after E5 with result_out=0xFE01, IDLE/ready_out=1 after E6.
- WIDTH=8, DIGIT_BITS=2; square_in=1, a=13, b=0xAA -> result_out=169 (0x00A9), N=2, valid_out after E3; b ignored.
- b=0 (and a=0, square) -> result_out=0, valid_out after E1. a=0, b=0xFF -> result 0 after E5 (no zero-operand shortcut on a).
- Backpressure: complete 7*9 then hold ack_in=0 for 10 cycles while pulsing start_in with new operands -> result_out=63 stable, valid_out=1, ready_out=0, no new operation. ack -> IDLE; next start then accepted.
- Abort and reset: abort_in at E2 of 0xFF*0xFF -> IDLE after E2, valid_out never rises, result_out keeps prior value. Separate run: rst_n_in low mid-MULT asynchronously (between edges) -> all outputs at reset values immediately, ready_out=1 after release.
- Sweep: WIDTH in {8,64,1024}, DIGIT_BITS in {1,4,8}; 2000 random a/b/square_in/ack-delay against a behavioural product model -> every result exact and latency equal to N+1.
